lcd_multi_ctrl: RTL and testbench
=================================

Name: lcd_multi_ctrl

Overview:
- Parametrised successor LCD controller for KS0066/HD44780-compatible character displays.
- Generalised over rows (1/2/4), columns (8..40) and bus width (8-bit or 4-bit nibble mode).
- Adds frame snapshotting, on-demand refresh, a busy flag and a frame-done strobe.
- Sits between the clock/time formatting logic, which supplies a flat character buffer, and the LCD pins.

Parameters:
- MFREQ_KHZ, 1: main clock in kHz. 1 ms = MFREQ_KHZ cycles. Set 20000 on the Vaman board.
- ROWS, 2: display rows; legal values 1, 2, 4.
- COLS, 16: characters per row; legal range 8..40.
- BUS4, 0: 0 = 8-bit bus, 1 = 4-bit bus (upper nibble on DB[7:4]).
- E_CYC, 1: cycles E is held high per transfer; must be ≥1.
- POWERUP_MS, 40: wait after reset before the first init command.
- INS_WAIT_MS, 10: wait after each instruction transfer.
- DATA_WAIT_MS, 10: wait after each character transfer.
- REFRESH_MS, 320: idle gap between automatic frames.

Ports:
- mclk  input  1  main clock
- rst  input  1  reset; synchronous, active-high
- text  input  8*ROWS*COLS  character codes. Byte k (bits 8k+7:8k) = row k/COLS, column k%COLS. Byte 0 is row 0, leftmost.
- refresh_req  input  1  single-cycle request for an immediate frame
- DB  output  8  LCD data bus; DB[3:0] driven 0 when BUS4=1
- RS  output  1  register select: 0 = instruction, 1 = data
- E  output  1  enable strobe
- RW  output  1  read/write; held 0 (write only)
- busy  output  1  high from reset until the end of init, and during every frame
- frame_done  output  1  one-cycle pulse after the last character wait of a frame

Behaviour:
- Reset values: DB=0, RS=0, E=0, RW=0, busy=1, frame_done=0. State=POWERUP, all counters 0, pending flag cleared.
- rst asserted in any state, including mid-transfer with E high, returns to this reset state on the next edge. Init then restarts from POWERUP.
- Wait counters are 32-bit. A wait of N ms lasts N*MFREQ_KHZ cycles. A wait of 0 ms lasts 0 cycles.
- Transfer primitive, byte b with RS value r:
  - Cycle 0: RS=r, DB=b (or high nibble), E=0.
  - Cycles 1..E_CYC: E=1.
  - Then E=0, with DB/RS held through the wait.
- BUS4=1 sends two nibble primitives, high then low, with a 1-cycle gap and no wait between them. The wait follows the low nibble.
- In 8-bit mode, transfer spacing is 1+E_CYC+wait cycles.
- States: POWERUP, INIT, IDLE, SNAP, SETADDR, WRCHAR, WAIT.
- POWERUP: wait POWERUP_MS, then go to INIT.
- INIT, BUS4=0: instructions 0x38, 0x0C, 0x01, 0x06, each followed by INS_WAIT_MS.
- INIT, BUS4=1:
  - First send single nibbles 0x3, 0x3, 0x3, 0x2, each followed by INS_WAIT_MS.
  - Then full bytes 0x28, 0x0C, 0x01, 0x06.
  - 0x28 is used for ROWS≥2; 0x20 is used for ROWS=1, and 0x30 replaces 0x38 likewise in 8-bit mode.
- After INIT, start the first frame immediately (go to SNAP).
- SNAP: copy text into an internal frame buffer in one cycle; busy=1. Changes to text during a frame do not affect that frame.
- Row r base DDRAM addresses: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS.
- SETADDR: send instruction 0x80|base(r), followed by INS_WAIT_MS.
- WRCHAR: send COLS data bytes (RS=1), each followed by DATA_WAIT_MS. Then go to the next row's SETADDR.
- After the last row: pulse frame_done for 1 cycle, go to IDLE, drop busy.
- IDLE: count REFRESH_MS from IDLE entry, then go to SNAP.
  - refresh_req in IDLE goes to SNAP on the next cycle and resets the idle count.
  - refresh_req simultaneous with idle-count expiry starts a single frame.
- refresh_req while busy (INIT or frame) sets a pending flag. Multiple requests collapse into one.
- A pending flag at frame end skips the REFRESH wait: frame_done pulses, then SNAP follows on the next cycle, and the flag clears.
- A pending flag raised during INIT is absorbed by the first frame.
- Frame length, 8-bit mode: ROWS*(1+E_CYC+INS_WAIT) + ROWS*COLS*(1+E_CYC+DATA_WAIT) cycles.

Test Plan:
- Reset timing. Config: MFREQ_KHZ=1, POWERUP_MS=3, INS=2, DATA=1, E_CYC=1, BUS4=0, ROWS=2, COLS=16.
  - Apply reset -> first E rise at cycle 4 after rst release.
  - Expect instructions 0x38, 0x0C, 0x01, 0x06 spaced 4 cycles apart.
  - Expect frame_done exactly 104 cycles after the first 0x80 transfer.
- Row addressing and character order. ROWS=4, COLS=20, text holds the ASCII index per byte.
  - Expect address instructions 0x80, 0xC0, 0x94, 0xD4.
  - Expect 80 data bytes in buffer order, RS=1 on each.
- Nibble mode. BUS4=1.
  - Expect init nibbles 3, 3, 3, 2 on DB[7:4] with DB[3:0]=0.
  - Character 0x41 must appear as nibble 0x4 then 0x1, with 2 E pulses separated by a 1-cycle gap.
- Snapshot. Change text mid-frame.
  - Current frame shows only the old bytes.
  - Next frame, after REFRESH_MS=5 cycles of IDLE, shows the new bytes.
- Refresh requests.
  - 3 refresh_req pulses during a frame -> exactly 1 extra frame, SNAP on the cycle after frame_done.
  - 1 refresh_req in IDLE -> SNAP on the next cycle.
- Reset during a transfer. Assert rst while E=1.
  - Next cycle: E=0, DB=0, busy=1.
  - Full init sequence replays.

Source files
------------

// File: rtl/lcd_multi_ctrl.sv
// HD44780/KS0066 character-LCD controller: parametrised rows/columns/bus width,
// snapshots a flat text buffer per frame, auto and on-demand refresh.
module lcd_multi_ctrl #(
  parameter int MFREQ_KHZ    = 1,
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int BUS4         = 0,
  parameter int E_CYC        = 1,
  parameter int POWERUP_MS   = 40,
  parameter int INS_WAIT_MS  = 10,
  parameter int DATA_WAIT_MS = 10,
  parameter int REFRESH_MS   = 320
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [8*ROWS*COLS-1:0]   text,
  input  logic                     refresh_req,
  output logic [7:0]               DB,
  output logic                     RS,
  output logic                     E,
  output logic                     RW,
  output logic                     busy,
  output logic                     frame_done,
  output logic [2:0]               o_dbg_state
);

  localparam logic [31:0] PU_CYC   = 32'(POWERUP_MS * MFREQ_KHZ);
  localparam logic [31:0] INS_CYC  = 32'(INS_WAIT_MS * MFREQ_KHZ);
  localparam logic [31:0] DATA_CYC = 32'(DATA_WAIT_MS * MFREQ_KHZ);
  localparam logic [31:0] REF_CYC  = 32'(REFRESH_MS * MFREQ_KHZ);
  localparam int          INIT_N   = (BUS4 != 0) ? 8 : 4;
  localparam int          PH_W     = $clog2(E_CYC + 1);
  localparam logic [7:0]  FSET     = (BUS4 != 0) ? ((ROWS >= 2) ? 8'h28 : 8'h20)
                                                 : ((ROWS >= 2) ? 8'h38 : 8'h30);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_IDLE, S_SNAP, S_SETADDR, S_WRCHAR, S_WAIT
  } state_t;

  state_t                  r_state, r_kind, w_next, w_kind, w_after;
  logic [31:0]             r_cnt;
  logic [PH_W-1:0]         r_ph;
  logic                    r_nib;
  logic [2:0]              r_idx;
  logic [1:0]              r_row;
  logic [5:0]              r_col;
  logic [8*ROWS*COLS-1:0]  r_frame;
  logic [7:0]              r_db;
  logic                    r_rs;
  logic                    r_pend;
  logic                    r_fd;

  logic        w_xfer, w_two, w_xfer_last, w_step_done, w_frame_end;
  logic        w_last_col, w_last_row, w_pu_done, w_idle_exp;
  logic [31:0] w_wait;
  logic [7:0]  w_byte, w_base, w_char, w_db_out;
  int          w_cidx;

  // Valid/ready does not apply here: the LCD is a timed write-only sink, so
  // every transfer is a fixed setup/E-high sequence followed by a fixed wait.
  always_comb begin
    w_xfer      = (r_state == S_INIT) || (r_state == S_SETADDR) || (r_state == S_WRCHAR);
    w_kind      = (r_state == S_WAIT) ? r_kind : r_state;
    w_wait      = (w_kind == S_WRCHAR) ? DATA_CYC : INS_CYC;
    w_two       = (BUS4 != 0) && !((r_state == S_INIT) && (r_idx < 3'd4));
    w_xfer_last = w_xfer && (r_ph == PH_W'(E_CYC)) && (!w_two || r_nib);
    w_step_done = ((r_state == S_WAIT) && (r_cnt == w_wait - 32'd1)) ||
                  (w_xfer_last && (w_wait == 32'd0));
    w_last_col  = (r_col == 6'(COLS - 1));
    w_last_row  = (r_row == 2'(ROWS - 1));
    w_frame_end = w_step_done && (w_kind == S_WRCHAR) && w_last_col && w_last_row;
    w_pu_done   = ({1'b0, r_cnt} + 33'd1) >= {1'b0, PU_CYC};
    w_idle_exp  = ({1'b0, r_cnt} + 33'd1) >= {1'b0, REF_CYC};
  end

  always_comb begin
    w_base = (r_row[0] ? 8'h40 : 8'h00) + (r_row[1] ? 8'(COLS) : 8'h00);
    w_cidx = int'(r_row) * COLS + int'(r_col);
    w_char = 8'(r_frame >> (8 * w_cidx));
    w_byte = 8'h00;
    case (r_state)
      S_INIT: begin
        if (BUS4 != 0) begin
          case (r_idx)
            3'd0, 3'd1, 3'd2: w_byte = 8'h30;
            3'd3:             w_byte = 8'h20;
            3'd4:             w_byte = FSET;
            3'd5:             w_byte = 8'h0C;
            3'd6:             w_byte = 8'h01;
            default:          w_byte = 8'h06;
          endcase
        end else begin
          case (r_idx)
            3'd0:    w_byte = FSET;
            3'd1:    w_byte = 8'h0C;
            3'd2:    w_byte = 8'h01;
            default: w_byte = 8'h06;
          endcase
        end
      end
      S_SETADDR: w_byte = 8'h80 | w_base;
      S_WRCHAR:  w_byte = w_char;
      default:   w_byte = 8'h00;
    endcase
    if (BUS4 == 0)
      w_db_out = w_byte;
    else if (w_two && r_nib)
      w_db_out = {w_byte[3:0], 4'h0};
    else
      w_db_out = {w_byte[7:4], 4'h0};
  end

  always_comb begin
    case (w_kind)
      S_INIT:    w_after = (r_idx == 3'(INIT_N - 1)) ? S_SNAP : S_INIT;
      S_SETADDR: w_after = S_WRCHAR;
      S_WRCHAR:  w_after = w_last_col ? (w_last_row ? S_IDLE : S_SETADDR) : S_WRCHAR;
      default:   w_after = S_IDLE;
    endcase
    w_next = r_state;
    case (r_state)
      S_POWERUP: if (w_pu_done) w_next = S_INIT;
      S_IDLE:    if (refresh_req || r_pend || w_idle_exp) w_next = S_SNAP;
      S_SNAP:    w_next = S_SETADDR;
      S_INIT, S_SETADDR, S_WRCHAR, S_WAIT: begin
        if (w_xfer_last && (w_wait != 32'd0)) w_next = S_WAIT;
        else if (w_step_done)                 w_next = w_after;
      end
      default:   w_next = S_POWERUP;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state <= S_POWERUP;
      r_kind  <= S_POWERUP;
      r_cnt   <= 32'd0;
      r_ph    <= '0;
      r_nib   <= 1'b0;
      r_idx   <= 3'd0;
      r_row   <= 2'd0;
      r_col   <= 6'd0;
      r_frame <= '0;
      r_db    <= 8'h00;
      r_rs    <= 1'b0;
      r_pend  <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_fd    <= w_frame_end;
      if (w_xfer) begin
        r_kind <= r_state;
        r_db   <= w_db_out;
        r_rs   <= (r_state == S_WRCHAR);
        if (r_ph == PH_W'(E_CYC)) begin
          r_ph  <= '0;
          r_nib <= w_xfer_last ? 1'b0 : 1'b1;
        end else begin
          r_ph  <= r_ph + 1'b1;
        end
      end
      if (w_step_done) begin
        case (w_kind)
          S_INIT:    r_idx <= (r_idx == 3'(INIT_N - 1)) ? 3'd0 : r_idx + 3'd1;
          S_SETADDR: r_col <= 6'd0;
          S_WRCHAR: begin
            if (w_last_col) begin
              r_col <= 6'd0;
              r_row <= w_last_row ? 2'd0 : r_row + 2'd1;
            end else begin
              r_col <= r_col + 6'd1;
            end
          end
          default: ;
        endcase
      end
      if (r_state == S_SNAP)
        r_frame <= text;
      // A request arriving in the SNAP cycle belongs to the next frame.
      if (r_state == S_SNAP)
        r_pend <= refresh_req;
      else if ((r_state != S_IDLE) && refresh_req)
        r_pend <= 1'b1;
    end
  end

  assign DB          = w_xfer ? w_db_out : r_db;
  assign RS          = w_xfer ? (r_state == S_WRCHAR) : r_rs;
  assign E           = w_xfer && (r_ph != '0);
  assign RW          = 1'b0;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_fd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_multi_ctrl.sv
// Bench for lcd_multi_ctrl: an 8-bit 2x16 instance and a 4-bit 4x20 instance,
// bus activity compared against a transfer-list model of the display protocol.
module tb_lcd_multi_ctrl;

  localparam int P8_PU = 3, P8_INS = 2, P8_DATA = 1, P8_E = 1, P8_R = 2, P8_C = 16, P8_REF = 5;
  localparam int P4_PU = 2, P4_INS = 1, P4_DATA = 0, P4_E = 2, P4_R = 4, P4_C = 20, P4_REF = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [8*P8_R*P8_C-1:0] text8;
  logic [8*P4_R*P4_C-1:0] text4;
  logic       req8 = 1'b0, req4 = 1'b0;
  logic [7:0] db8, db4;
  logic       rs8, e8, rw8, busy8, fd8, rs4, e4, rw4, busy4, fd4;
  logic [2:0] dbg8, dbg4;

  lcd_multi_ctrl #(
    .MFREQ_KHZ(1), .ROWS(P8_R), .COLS(P8_C), .BUS4(0), .E_CYC(P8_E),
    .POWERUP_MS(P8_PU), .INS_WAIT_MS(P8_INS), .DATA_WAIT_MS(P8_DATA), .REFRESH_MS(P8_REF)
  ) u_dut8 (
    .mclk(clk), .rst(rst), .text(text8), .refresh_req(req8),
    .DB(db8), .RS(rs8), .E(e8), .RW(rw8), .busy(busy8), .frame_done(fd8), .o_dbg_state(dbg8)
  );

  lcd_multi_ctrl #(
    .MFREQ_KHZ(1), .ROWS(P4_R), .COLS(P4_C), .BUS4(1), .E_CYC(P4_E),
    .POWERUP_MS(P4_PU), .INS_WAIT_MS(P4_INS), .DATA_WAIT_MS(P4_DATA), .REFRESH_MS(P4_REF)
  ) u_dut4 (
    .mclk(clk), .rst(rst), .text(text4), .refresh_req(req4),
    .DB(db4), .RS(rs4), .E(e4), .RW(rw4), .busy(busy4), .frame_done(fd4), .o_dbg_state(dbg4)
  );

  // scoreboard: events are {cycle of E rise, RW, RS, DB}
  logic [41:0] exp8_q[$], obs8_q[$], exp4_q[$], obs4_q[$];
  int          fde8_q[$], fdo8_q[$], fde4_q[$], fdo4_q[$];
  logic [7:0]  ta8[80], tb8[80], t4[80];
  int          n_vec = 0, n_err = 0;
  logic        e8_prev = 1'b0, e4_prev = 1'b0;

  always @(negedge clk) begin
    if (e8 && !e8_prev) obs8_q.push_back({32'(cyc), rw8, rs8, db8});
    if (e4 && !e4_prev) obs4_q.push_back({32'(cyc), rw4, rs4, db4});
    if (fd8) fdo8_q.push_back(cyc);
    if (fd4) fdo4_q.push_back(cyc);
    e8_prev = e8;
    e4_prev = e4;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: one protocol transfer starting with its setup cycle at t
  task automatic send(input bit four, input int t, input logic rs, input logic [7:0] b,
                      input bit nib_only, input int w, output int tn);
    int e;
    e = four ? P4_E : P8_E;
    if (!four) begin
      exp8_q.push_back({32'(t + 1), 1'b0, rs, b});
      tn = t + 1 + e + w;
    end else if (nib_only) begin
      exp4_q.push_back({32'(t + 1), 1'b0, rs, b[7:4], 4'h0});
      tn = t + 1 + e + w;
    end else begin
      exp4_q.push_back({32'(t + 1), 1'b0, rs, b[7:4], 4'h0});
      exp4_q.push_back({32'(t + 2 + e), 1'b0, rs, b[3:0], 4'h0});
      tn = t + 2 * (1 + e) + w;
    end
  endtask

  task automatic model_init(input bit four, output int snap);
    int t, ins, rows;
    logic [7:0] fs;
    ins  = four ? P4_INS : P8_INS;
    rows = four ? P4_R : P8_R;
    t    = four ? P4_PU : P8_PU;
    if (four) begin
      for (int i = 0; i < 4; i++) send(1'b1, t, 1'b0, (i == 3) ? 8'h20 : 8'h30, 1'b1, ins, t);
      fs = (rows >= 2) ? 8'h28 : 8'h20;
    end else begin
      fs = (rows >= 2) ? 8'h38 : 8'h30;
    end
    send(four, t, 1'b0, fs,    1'b0, ins, t);
    send(four, t, 1'b0, 8'h0C, 1'b0, ins, t);
    send(four, t, 1'b0, 8'h01, 1'b0, ins, t);
    send(four, t, 1'b0, 8'h06, 1'b0, ins, t);
    snap = t;
  endtask

  // src: 0 = first 8-bit text, 1 = second 8-bit text, 2 = 4-bit text
  task automatic model_frame(input bit four, input int snap, input int src, output int fd);
    int t, rows, cols, ins, dat;
    logic [7:0] ch;
    rows = four ? P4_R : P8_R;
    cols = four ? P4_C : P8_C;
    ins  = four ? P4_INS : P8_INS;
    dat  = four ? P4_DATA : P8_DATA;
    t    = snap + 1;
    for (int r = 0; r < rows; r++) begin
      send(four, t, 1'b0, 8'h80 | 8'((r % 2) * 64 + (r / 2) * cols), 1'b0, ins, t);
      for (int c = 0; c < cols; c++) begin
        ch = (src == 0) ? ta8[r*cols+c] : (src == 1) ? tb8[r*cols+c] : t4[r*cols+c];
        send(four, t, 1'b1, ch, 1'b0, dat, t);
      end
    end
    fd = t;
    if (four) fde4_q.push_back(fd);
    else      fde8_q.push_back(fd);
  endtask

  task automatic cmp_ev(input bit four, input string tag);
    logic [41:0] e, o;
    int n;
    n = four ? exp4_q.size() : exp8_q.size();
    for (int i = 0; i < n; i++) begin
      o = '0;
      if (four) begin
        e = exp4_q.pop_front();
        if (obs4_q.size() > 0) o = obs4_q.pop_front();
      end else begin
        e = exp8_q.pop_front();
        if (obs8_q.size() > 0) o = obs8_q.pop_front();
      end
      chk($sformatf("%s[%0d]", tag, i), 64'(o), 64'(e));
    end
  endtask

  task automatic cmp_fd(input bit four, input string tag);
    int e, o, n;
    n = four ? fde4_q.size() : fde8_q.size();
    for (int i = 0; i < n; i++) begin
      o = -1;
      if (four) begin
        e = fde4_q.pop_front();
        if (fdo4_q.size() > 0) o = fdo4_q.pop_front();
      end else begin
        e = fde8_q.pop_front();
        if (fdo8_q.size() > 0) o = fdo8_q.pop_front();
      end
      chk($sformatf("%s[%0d]", tag, i), 64'(o), 64'(e));
    end
  endtask

  // driver tasks
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_req8(input int c);
    wait_until(c);
    req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_db8"}, 64'(db8), 64'h00);
    chk({tag, "_rs8"}, 64'(rs8), 64'h0);
    chk({tag, "_e8"}, 64'(e8), 64'h0);
    chk({tag, "_rw8"}, 64'(rw8), 64'h0);
    chk({tag, "_busy8"}, 64'(busy8), 64'h1);
    chk({tag, "_fd8"}, 64'(fd8), 64'h0);
    chk({tag, "_db4"}, 64'(db4), 64'h00);
    chk({tag, "_e4"}, 64'(e4), 64'h0);
    chk({tag, "_busy4"}, 64'(busy4), 64'h1);
  endtask

  int s8, f1, s2, f2, s3, f3, s4, f4, s5, f5, s6, f6, g0, g1, g2, k;

  initial begin
    for (int i = 0; i < 80; i++) begin
      ta8[i] = 8'($urandom_range(32, 126));
      tb8[i] = 8'($urandom_range(32, 126));
      if (tb8[i] == ta8[i]) tb8[i] = ta8[i] ^ 8'h40;
      t4[i]  = 8'(i);
    end
    for (int i = 0; i < P8_R * P8_C; i++) text8[8*i +: 8] = ta8[i];
    for (int i = 0; i < P4_R * P4_C; i++) text4[8*i +: 8] = t4[i];

    // reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    model_init(1'b0, s8);
    model_frame(1'b0, s8, 0, f1);
    s2 = f1 + P8_REF;
    model_frame(1'b0, s2, 1, f2);
    model_init(1'b1, g0);
    model_frame(1'b1, g0, 2, g1);
    model_frame(1'b1, g1 + P4_REF, 2, g2);

    // snapshot: text changes mid-frame
    wait_until(s8 + 40);
    for (int i = 0; i < P8_R * P8_C; i++) text8[8*i +: 8] = tb8[i];
    wait_until(s2 + 20);
    chk("busy_in_frame", 64'(busy8), 64'h1);
    wait_until(f2 + 1);
    chk("busy_in_idle", 64'(busy8), 64'h0);

    // request in IDLE, then three requests during a frame, then one at idle expiry
    pulse_req8(f2 + 2);
    s3 = f2 + 3;
    model_frame(1'b0, s3, 1, f3);
    pulse_req8(s3 + 10);
    pulse_req8(s3 + 30);
    pulse_req8(s3 + 60);
    s4 = f3 + 1;
    model_frame(1'b0, s4, 1, f4);
    pulse_req8(f4 + P8_REF - 1);
    s5 = f4 + P8_REF;
    model_frame(1'b0, s5, 1, f5);
    s6 = f5 + P8_REF;
    model_frame(1'b0, s6, 1, f6);
    wait_until(f6 + 2);

    if (obs8_q.size() > 4) begin
      chk("first_e_rise", 64'(obs8_q[0][41:10]), 64'd4);
      chk("first_setaddr", 64'(obs8_q[4][7:0]), 64'h80);
      if (fdo8_q.size() > 0)
        chk("frame_len", 64'(fdo8_q[0] - (int'(obs8_q[4][41:10]) - 1)), 64'd104);
      else
        chk("frame_len_fd_seen", 64'(fdo8_q.size()), 64'd1);
    end else begin
      chk("bus8_events_seen", 64'(obs8_q.size()), 64'd5);
    end
    cmp_ev(1'b0, "bus8");
    cmp_fd(1'b0, "fdone8");

    wait_until(g2 + 2);
    cmp_ev(1'b1, "bus4");
    cmp_fd(1'b1, "fdone4");

    // reset while E is high
    k = 0;
    while (!e8 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("e_high_seen", 64'(e8), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b0;
    obs8_q.delete();
    obs4_q.delete();
    fdo8_q.delete();
    fdo4_q.delete();
    model_init(1'b0, s8);
    model_init(1'b1, g0);
    wait_until(g0 + 3);
    cmp_ev(1'b0, "reinit8");
    cmp_ev(1'b1, "reinit4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
